// File: rtl/lcd_ctrl.sv
// lcd_ctrl -- HD44780-compatible character-LCD interface controller.
//
// Accepts LCD commands from the load/store unit into a small circular FIFO,
// then replays each one onto the LCD pins as a setup / enable-pulse / hold
// sequence. After the hold phase it waits out the LCD execution time before
// starting the next command. Clear and home commands get the long wait.
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous, active-high reset
//   cmd_valid_i  LSU presents a command
//   cmd_i        [8] = RS (1 data, 0 instruction), [7:0] = LCD byte
//   cmd_ready_o  FIFO not full; a command is taken on valid && ready
//   lcd_on_i     backlight/power request from the LSU register
//   busy_o       FIFO non-empty or a transaction in progress
//   level_o      number of FIFO entries currently held
//   lcd_on_o     registered copy of lcd_on_i
//   lcd_en_o     LCD enable strobe (register output)
//   lcd_rs_o     LCD register select
//   lcd_rw_o     LCD read/write select, always 0 (write-only)
//   lcd_data_o   LCD data bus
module lcd_ctrl #(
    parameter int DEPTH       = 4,
    parameter int T_SETUP     = 2,
    parameter int T_PW        = 12,
    parameter int T_HOLD      = 2,
    parameter int T_EXEC      = 1850,
    parameter int T_EXEC_LONG = 76000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cmd_valid_i,
    input  logic [8:0]               cmd_i,
    output logic                     cmd_ready_o,
    input  logic                     lcd_on_i,
    output logic                     busy_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     lcd_on_o,
    output logic                     lcd_en_o,
    output logic                     lcd_rs_o,
    output logic                     lcd_rw_o,
    output logic [7:0]               lcd_data_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(T_EXEC_LONG + 1);

    // Counters load "duration - 1" on state entry so that a phase lasting
    // N cycles ends exactly N edges after it was entered.
    localparam logic [CW-1:0] SETUP_LD = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] PW_LD    = CW'(T_PW - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] EXEC_LD  = CW'(T_EXEC - 1);
    localparam logic [CW-1:0] LONG_LD  = CW'(T_EXEC_LONG - 1);
    localparam logic [LW-1:0] FULL     = LW'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        EN_HI,
        HOLD,
        EXEC
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;
    logic            long_wait;
    logic            long_next;
    logic            pop;
    logic            push;

    logic [8:0]      mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [LW-1:0]   level;
    logic [8:0]      head;
    logic            head_long;

    assign cmd_ready_o = (level != FULL);
    assign push        = cmd_valid_i && cmd_ready_o;
    assign level_o     = level;
    assign head        = mem[rd_ptr];
    assign busy_o      = (state != IDLE) || (level != '0);
    assign lcd_rw_o    = 1'b0;

    // Clear (0x01) and home (0x02/0x03) are the only instructions that need
    // the long execution wait.
    assign head_long = !head[8] && (head[7:2] == 6'd0) && (head[1:0] != 2'd0);

    // FIFO storage. Contents need no reset: the pointers and level decide
    // what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= cmd_i;
        end
    end

    // FIFO pointers and occupancy. Pointers wrap naturally because DEPTH is
    // a power of two; a simultaneous push and pop leaves the level alone.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end

    // Next-state logic. A pop happens either from IDLE or directly at the
    // end of EXEC, so back-to-back commands never see an idle bubble.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        long_next  = long_wait;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (level != '0) begin
                    pop        = 1'b1;
                    next_state = SETUP;
                    cnt_next   = SETUP_LD;
                    long_next  = head_long;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    next_state = EN_HI;
                    cnt_next   = PW_LD;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            EN_HI: begin
                if (cnt == '0) begin
                    next_state = HOLD;
                    cnt_next   = HOLD_LD;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    next_state = EXEC;
                    cnt_next   = long_wait ? LONG_LD : EXEC_LD;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            EXEC: begin
                if (cnt == '0) begin
                    if (level != '0) begin
                        pop        = 1'b1;
                        next_state = SETUP;
                        cnt_next   = SETUP_LD;
                        long_next  = head_long;
                    end else begin
                        next_state = IDLE;
                        cnt_next   = '0;
                    end
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State register and pin drivers. EN is registered from the next state
    // so it is glitch-free and high only while in EN_HI. RS/data are only
    // updated on a pop, so they stay stable between commands.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            cnt        <= '0;
            long_wait  <= 1'b0;
            lcd_en_o   <= 1'b0;
            lcd_rs_o   <= 1'b0;
            lcd_data_o <= 8'd0;
        end else begin
            state     <= next_state;
            cnt       <= cnt_next;
            long_wait <= long_next;
            lcd_en_o  <= (next_state == EN_HI);
            if (pop) begin
                lcd_rs_o   <= head[8];
                lcd_data_o <= head[7:0];
            end
        end
    end

    // Power/backlight request is simply re-timed, independent of the FSM.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lcd_on_o <= 1'b0;
        end else begin
            lcd_on_o <= lcd_on_i;
        end
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl -- self-checking bench for lcd_ctrl.
//
// A timeline model predicts every output after every clock edge: it keeps
// the queue of accepted commands, the edge of the latest pop and the
// earliest edge the next pop may happen, and derives EN/RS/data/busy from
// those with plain arithmetic. Directed scenarios are followed by a
// randomized phase.
module tb_lcd_ctrl;

    localparam int DEPTH = 4;
    localparam int S     = 2;
    localparam int P     = 4;
    localparam int H     = 2;
    localparam int W     = 10;
    localparam int WL    = 50;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i;
    logic [8:0]  cmd_i;
    logic        cmd_ready_o;
    logic        lcd_on_i;
    logic        busy_o;
    logic [2:0]  level_o;
    logic        lcd_on_o;
    logic        lcd_en_o;
    logic        lcd_rs_o;
    logic        lcd_rw_o;
    logic [7:0]  lcd_data_o;

    lcd_ctrl #(
        .DEPTH(DEPTH), .T_SETUP(S), .T_PW(P), .T_HOLD(H),
        .T_EXEC(W), .T_EXEC_LONG(WL)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cmd_valid_i(cmd_valid_i),
        .cmd_i(cmd_i), .cmd_ready_o(cmd_ready_o), .lcd_on_i(lcd_on_i),
        .busy_o(busy_o), .level_o(level_o), .lcd_on_o(lcd_on_o),
        .lcd_en_o(lcd_en_o), .lcd_rs_o(lcd_rs_o), .lcd_rw_o(lcd_rw_o),
        .lcd_data_o(lcd_data_o)
    );

    always #5 clk_i = ~clk_i;

    int         checks = 0;
    int         errors = 0;
    int         n = 0;
    logic [8:0] q[$];
    logic [8:0] cur_cmd = 9'd0;
    int         pop_edge = -1000;
    int         free_at = 0;
    logic       exp_on = 1'b0;
    logic       last_acc = 1'b0;
    logic       prev_en = 1'b0;
    int         rise_log[$];

    function automatic bit is_long(input logic [8:0] c);
        return !c[8] && (c[7:2] == 6'd0) && (c[1:0] != 2'd0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s edge %0d observed %0h expected %0h", tag, n, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic v, input logic [8:0] c, input logic o);
        rst_i       = r;
        cmd_valid_i = v;
        cmd_i       = c;
        lcd_on_i    = o;
    endtask

    // Advance the model by one edge using the inputs that were held at it.
    task automatic model_update();
        int  pre;
        bit  do_pop;
        n++;
        if (rst_i) begin
            q.delete();
            cur_cmd  = 9'd0;
            pop_edge = -1000;
            free_at  = n;
            exp_on   = 1'b0;
            last_acc = 1'b0;
        end else begin
            pre      = q.size();
            do_pop   = (pre != 0) && (n >= free_at);
            last_acc = cmd_valid_i && (pre != DEPTH);
            if (do_pop) begin
                cur_cmd  = q.pop_front();
                pop_edge = n;
                free_at  = n + S + P + H + (is_long(cur_cmd) ? WL : W);
            end
            if (last_acc) begin
                q.push_back(cmd_i);
            end
            exp_on = lcd_on_i;
        end
    endtask

    task automatic check_output();
        logic en_exp;
        en_exp = (n >= pop_edge + S) && (n < pop_edge + S + P);
        chk("en",    32'(lcd_en_o),    32'(en_exp));
        chk("rs",    32'(lcd_rs_o),    32'(cur_cmd[8]));
        chk("data",  32'(lcd_data_o),  32'(cur_cmd[7:0]));
        chk("rw",    32'(lcd_rw_o),    32'd0);
        chk("ready", 32'(cmd_ready_o), 32'(q.size() != DEPTH));
        chk("level", 32'(level_o),     32'(q.size()));
        chk("busy",  32'(busy_o),      32'((n < free_at) || (q.size() != 0)));
        chk("on",    32'(lcd_on_o),    32'(exp_on));
        if (lcd_en_o === 1'b1 && prev_en !== 1'b1) begin
            rise_log.push_back(n);
        end
        prev_en = lcd_en_o;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        model_update();
        check_output();
    endtask

    initial begin
        int  idx;
        int  rises_before;
        bit  v;
        logic [8:0] c;

        $display("[TB] start");
        apply_stimulus(1'b1, 1'b0, 9'd0, 1'b0);
        tick();
        tick();
        apply_stimulus(1'b0, 1'b0, 9'd0, 1'b0);
        tick();
        tick();

        // Single data command.
        apply_stimulus(1'b0, 1'b1, 9'h141, 1'b1);
        tick();
        apply_stimulus(1'b0, 1'b0, 9'h000, 1'b0);
        repeat (25) tick();

        // Clear followed by a data write: EN rises are one long period apart.
        apply_stimulus(1'b0, 1'b1, 9'h001, 1'b1);
        tick();
        apply_stimulus(1'b0, 1'b1, 9'h180, 1'b0);
        tick();
        apply_stimulus(1'b0, 1'b0, 9'h000, 1'b1);
        repeat (140) tick();
        if (rise_log.size() >= 2) begin
            chk("clear_spacing", 32'(rise_log[rise_log.size()-1] - rise_log[rise_log.size()-2]),
                32'(S + P + H + WL));
        end else begin
            chk("clear_rises", 32'(rise_log.size()), 32'd2);
        end

        // Back-pressure: six commands offered continuously.
        idx = 0;
        repeat (200) begin
            apply_stimulus(1'b0, idx < 6, 9'h130 + 9'(idx), 1'b0);
            tick();
            if (last_acc) idx++;
        end
        chk("bp_accepted", 32'(idx), 32'd6);

        // Reset while EN is high with three commands still queued.
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, 1'b1, 9'h141 + 9'(i), 1'b0);
            tick();
        end
        apply_stimulus(1'b1, 1'b0, 9'h000, 1'b0);
        tick();
        chk("rst_en", 32'(lcd_en_o), 32'd0);
        apply_stimulus(1'b0, 1'b0, 9'h000, 1'b0);
        rises_before = rise_log.size();
        repeat (120) tick();
        chk("rst_no_replay", 32'(rise_log.size()), 32'(rises_before));

        // Keep two entries queued by pushing on each pop edge, wrapping the
        // pointers three times.
        idx = 0;
        repeat (400) begin
            v = (idx < 3 * DEPTH) &&
                ((q.size() < 2) || ((q.size() != 0) && (n + 1 >= free_at)));
            apply_stimulus(1'b0, v, {1'b1, 8'($urandom)}, 1'b1);
            tick();
            if (last_acc) idx++;
        end
        chk("wrap_accepted", 32'(idx), 32'(3 * DEPTH));

        // Randomized traffic, including clear/home and occasional resets.
        repeat (900) begin
            c = 9'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                c = {7'd0, 2'($urandom_range(1, 3))};
            end
            apply_stimulus($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
                           c, 1'($urandom_range(0, 1)));
            tick();
        end
        apply_stimulus(1'b0, 1'b0, 9'h000, 1'b0);
        repeat (100) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
